pc_fetch_sequencer: RTL and testbench

Multi-cycle fetch/redirect sequencer in front of the branch control unit. It owns the program counter, fetches instructions over a req/ack instruction-memory handshake, and presents each instruction to decode. When decode accepts, it consumes the resolved branch decision (BranchCtr) plus jump/jr controls and computes the next fetch address. It also flags misaligned targets and counts taken redirects.

---
 rtl/pc_fetch_sequencer.sv | 128 ++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner: fetches over a req/ack imem handshake, holds the
// instruction for decode and redirects on jr/jump/taken-branch.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic             instr_valid,
    output logic [31:0]      instr_out,
    output logic [31:0]      instr_pc,
    input  logic             stall,
    input  logic             branch_take,
    input  logic             jump,
    input  logic             jr,
    input  logic [31:0]      jr_target,
    output logic             addr_err,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        VALID,
        HALT
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      ipc_q, ipc_d;
    logic             addr_err_q, addr_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0] pc4;
    logic [31:0] br_off;
    logic [31:0] next_pc;
    logic        redirect;

    assign pc4      = ipc_q + 32'd4;
    assign br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign redirect = jr | jump | branch_take;

    always_comb begin
        next_pc = pc4;
        if (jr) begin
            next_pc = jr_target;
        end else if (jump) begin
            next_pc = {pc4[31:28], instr_q[25:0], 2'b00};
        end else if (branch_take) begin
            next_pc = pc4 + br_off;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        instr_d    = instr_q;
        ipc_d      = ipc_q;
        addr_err_d = addr_err_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            BOOT: begin
                state_d    = FETCH;
                fetch_pc_d = RESET_PC;
            end
            FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    ipc_d   = fetch_pc_q;
                    state_d = VALID;
                end
            end
            VALID: begin
                // control inputs matter only in the accept cycle
                if (!stall) begin
                    if (next_pc[1:0] != 2'b00) begin
                        addr_err_d = 1'b1;
                        state_d    = HALT;
                    end else begin
                        fetch_pc_d = next_pc;
                        state_d    = FETCH;
                        if (redirect && cnt_q != '1) begin
                            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            instr_q    <= 32'd0;
            ipc_q      <= 32'd0;
            addr_err_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            instr_q    <= instr_d;
            ipc_q      <= ipc_d;
            addr_err_q <= addr_err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = fetch_pc_q;
    assign instr_valid = (state_q == VALID);
    assign instr_out   = instr_q;
    assign instr_pc    = ipc_q;
    assign addr_err    = addr_err_q;
    assign taken_cnt   = cnt_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboard bench for pc_fetch_sequencer: a memory/decoder driver feeds an
// architectural next-PC model; a monitor compares fetches and held instrs.
module tb_pc_fetch_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             imem_req;
    logic [31:0]      imem_addr;
    logic             imem_ack = 1'b0;
    logic [31:0]      imem_rdata = 32'd0;
    logic             instr_valid;
    logic [31:0]      instr_out;
    logic [31:0]      instr_pc;
    logic             stall = 1'b0;
    logic             branch_take = 1'b0;
    logic             jump = 1'b0;
    logic             jr = 1'b0;
    logic [31:0]      jr_target = 32'd0;
    logic             addr_err;
    logic [CNT_W-1:0] taken_cnt;

    pc_fetch_sequencer #(
        .RESET_PC(RESET_PC),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr_valid(instr_valid),
        .instr_out  (instr_out),
        .instr_pc   (instr_pc),
        .stall      (stall),
        .branch_take(branch_take),
        .jump       (jump),
        .jr         (jr),
        .jr_target  (jr_target),
        .addr_err   (addr_err),
        .taken_cnt  (taken_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          halt;
        logic [31:0] addr;
        int          cnt;
    } fexp_t;
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } iexp_t;
    typedef struct {
        int          delay;
        logic [31:0] rdata;
    } mem_t;
    typedef struct {
        int          stalls;
        bit          jr;
        bit          jump;
        bit          br;
        logic [31:0] tgt;
    } dec_t;

    fexp_t fq[$];
    iexp_t iq[$];
    mem_t  dmem[$];
    dec_t  ddec[$];

    int checks = 0;
    int passes = 0;

    logic [31:0] m_fetch_pc = RESET_PC;
    logic [31:0] m_instr = 32'd0;
    logic [31:0] m_ipc = 32'd0;
    int          m_cnt = 0;
    bit          mem_busy = 1'b0;
    bit          dec_busy = 1'b0;
    mem_t        cur_mem;
    dec_t        cur_dec;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Architectural next-PC rule applied to the accepted instruction.
    task automatic model_accept();
        logic [31:0] pc4;
        logic [31:0] nx;
        int          off;
        pc4 = m_ipc + 32'd4;
        off = int'($signed(m_instr[15:0]));
        if (cur_dec.jr) nx = cur_dec.tgt;
        else if (cur_dec.jump)
            nx = (pc4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) << 2);
        else if (cur_dec.br) nx = pc4 + 32'(off * 4);
        else nx = pc4;
        if (nx % 4 != 0) begin
            fq.push_back('{1'b1, 32'd0, m_cnt});
        end else begin
            if (cur_dec.jr || cur_dec.jump || cur_dec.br)
                m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            m_fetch_pc = nx;
            fq.push_back('{1'b0, nx, m_cnt});
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (imem_req) begin
            if (!mem_busy) begin
                if (dmem.size() > 0) begin
                    cur_mem = dmem.pop_front();
                end else begin
                    cur_mem.delay = ($urandom_range(0, 1) == 0) ? 0
                                  : int'($urandom_range(1, 3));
                    cur_mem.rdata = $urandom();
                end
                mem_busy = 1'b1;
            end
            if (cur_mem.delay == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = cur_mem.rdata;
                m_instr    = cur_mem.rdata;
                m_ipc      = m_fetch_pc;
                iq.push_back('{m_instr, m_ipc});
                mem_busy   = 1'b0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom();
                cur_mem.delay--;
            end
        end else begin
            imem_ack   = 1'($urandom());
            imem_rdata = $urandom();
        end
        if (instr_valid) begin
            if (!dec_busy) begin
                if (ddec.size() > 0) begin
                    cur_dec = ddec.pop_front();
                end else begin
                    cur_dec.stalls = ($urandom_range(0, 9) < 6) ? 0
                                   : int'($urandom_range(1, 5));
                    cur_dec.jr   = ($urandom_range(0, 99) < 15);
                    cur_dec.jump = ($urandom_range(0, 99) < 20);
                    cur_dec.br   = ($urandom_range(0, 99) < 35);
                    cur_dec.tgt  = $urandom();
                    if ($urandom_range(0, 7) != 0) cur_dec.tgt[1:0] = 2'b00;
                end
                dec_busy = 1'b1;
            end
            if (cur_dec.stalls > 0) begin
                stall       = 1'b1;
                branch_take = ~branch_take;
                jump        = 1'($urandom());
                jr          = 1'($urandom());
                jr_target   = $urandom();
                cur_dec.stalls--;
            end else begin
                stall       = 1'b0;
                jr          = cur_dec.jr;
                jump        = cur_dec.jump;
                branch_take = cur_dec.br;
                jr_target   = cur_dec.tgt;
                model_accept();
                dec_busy    = 1'b0;
            end
        end else begin
            stall       = 1'($urandom());
            branch_take = 1'($urandom());
            jump        = 1'($urandom());
            jr          = 1'($urandom());
            jr_target   = $urandom();
        end
    endtask

    task automatic do_reset(input int hold);
        @(negedge clk);
        chk("queues_drained", 32'(fq.size() + iq.size()), 32'd0);
        rst_n      = 1'b0;
        fq.delete();
        iq.delete();
        mem_busy   = 1'b0;
        dec_busy   = 1'b0;
        m_fetch_pc = RESET_PC;
        m_cnt      = 0;
        imem_ack   = 1'b1;
        imem_rdata = $urandom();
        repeat (hold) @(negedge clk);
        rst_n = 1'b1;
        fq.push_back('{1'b0, RESET_PC, 0});
    endtask

    initial begin : monitor
        bit          pr;
        bit          pv;
        bit          pe;
        bit          fresh;
        logic [31:0] caddr;
        iexp_t       ci;
        fexp_t       fe;
        pr = 0; pv = 0; pe = 0; fresh = 0;
        caddr = 32'd0;
        ci = '{32'd0, 32'd0};
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                chk("rst_imem_req", 32'(imem_req), 32'd0);
                chk("rst_imem_addr", imem_addr, RESET_PC);
                chk("rst_instr_valid", 32'(instr_valid), 32'd0);
                chk("rst_instr_out", instr_out, 32'd0);
                chk("rst_instr_pc", instr_pc, 32'd0);
                chk("rst_addr_err", 32'(addr_err), 32'd0);
                chk("rst_taken_cnt", 32'(taken_cnt), 32'd0);
                pr = 0; pv = 0; pe = 0; fresh = 1;
            end else begin
                if (fresh) chk("first_req_after_reset", 32'(imem_req), 32'd1);
                fresh = 0;
                if (imem_req && !pr) begin
                    if (fq.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_fetch: got addr %h expected none",
                                 imem_addr);
                    end else begin
                        fe = fq.pop_front();
                        chk("fetch_not_halt", 32'(fe.halt), 32'd0);
                        chk("fetch_addr", imem_addr, fe.addr);
                        chk("fetch_taken_cnt", 32'(taken_cnt), 32'(fe.cnt));
                    end
                    caddr = imem_addr;
                end else if (imem_req) begin
                    chk("addr_stable", imem_addr, caddr);
                end
                if (instr_valid && !pv) begin
                    if (iq.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_valid: got pc %h expected none",
                                 instr_pc);
                    end else begin
                        ci = iq.pop_front();
                    end
                end
                if (instr_valid) begin
                    chk("instr_out", instr_out, ci.instr);
                    chk("instr_pc", instr_pc, ci.pc);
                end
                if (addr_err && !pe) begin
                    if (fq.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_addr_err: got 1 expected 0");
                    end else begin
                        fe = fq.pop_front();
                        chk("halt_expected", 32'(fe.halt), 32'd1);
                        chk("halt_taken_cnt", 32'(taken_cnt), 32'(fe.cnt));
                    end
                end
                if (addr_err) begin
                    chk("halt_imem_req", 32'(imem_req), 32'd0);
                    chk("halt_instr_valid", 32'(instr_valid), 32'd0);
                end
                if (imem_req && instr_valid) begin
                    checks++;
                    $display("FAIL req_and_valid: got both 1 expected exclusive");
                end
                pr = imem_req;
                pv = instr_valid;
                pe = addr_err;
            end
        end
    end

    initial begin
        // Zero-wait stream, beq taken at 0x3010, jr back, beq not taken.
        for (int i = 0; i < 4; i++) dmem.push_back('{0, 32'(i)});
        dmem.push_back('{0, 32'h1000_FFFC});
        dmem.push_back('{0, 32'h0000_0000});
        dmem.push_back('{0, 32'h1000_FFFC});
        for (int i = 0; i < 4; i++) ddec.push_back('{0, 0, 0, 0, 32'd0});
        ddec.push_back('{0, 0, 0, 1, 32'd0});
        ddec.push_back('{0, 1, 0, 0, 32'h0000_3010});
        ddec.push_back('{0, 0, 0, 0, 32'd0});
        do_reset(2);
        for (int i = 0; i < 14; i++) begin
            step();
            chk("zero_wait_valid", 32'(instr_valid), 32'(i % 2));
            chk("zero_wait_req", 32'(imem_req), 32'((i + 1) % 2));
        end
        repeat (4) step();

        // jr to 0x3020, jump, jr-over-jump, stalled branch, misaligned jr.
        dmem.push_back('{0, $urandom()});
        dmem.push_back('{0, 32'h0800_0C40});
        dmem.push_back('{1, $urandom()});
        dmem.push_back('{0, 32'h1000_0002});
        dmem.push_back('{2, $urandom()});
        ddec.push_back('{0, 1, 0, 0, 32'h0000_3020});
        ddec.push_back('{0, 0, 1, 0, 32'd0});
        ddec.push_back('{0, 1, 1, 0, 32'h0000_4000});
        ddec.push_back('{5, 0, 0, 1, 32'd0});
        ddec.push_back('{0, 1, 0, 0, 32'h0000_3002});
        do_reset(1);
        repeat (40) step();

        // Reset lands while a 3-cycle-delayed fetch is outstanding.
        dmem.push_back('{3, $urandom()});
        do_reset(1);
        repeat (3) step();
        chk("dir_mem_consumed", 32'(dmem.size()), 32'd0);

        for (int e = 0; e < 40; e++) begin
            do_reset(int'($urandom_range(1, 2)));
            repeat ($urandom_range(10, 250)) step();
        end
        do_reset(1);
        repeat (4) step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
